// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver.
//
// Brings the asynchronous serial line into the clk domain through a
// two-flop synchroniser. It detects the falling edge of a start bit and
// re-checks it half a bit later, which rejects glitches. It then samples
// each data bit in the middle of its bit period and assembles the bits
// LSB first. A correctly framed byte is announced with a single-cycle
// rx_valid pulse. If the stop bit is low, the receiver raises a
// single-cycle framing_err pulse and leaves rx_byte unchanged.
//
// Parameters
//   F_CLK        system clock frequency in Hz
//   BAUD         line rate in bit/s; F_CLK/BAUD must be at least 4
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   rst_n        synchronous reset, active low
//   rx_serial    asynchronous serial input, idle high
//   rx_byte      last correctly framed byte, held until the next good frame
//   rx_valid     1-cycle pulse: rx_byte was updated this cycle
//   rx_active    high while a frame is in progress (start bit up to stop sample)
//   framing_err  1-cycle pulse: the stop bit was sampled low
module uart_rx #(
  parameter int F_CLK = 100000000,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       framing_err
);

  localparam int CLKS_PER_BIT = F_CLK / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CLEANUP = 3'd4;

  logic [2:0]  state_reg;
  logic [15:0] clk_count_reg;
  logic [2:0]  bit_index_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  rx_byte_reg;
  logic        rx_valid_reg;
  logic        rx_active_reg;
  logic        framing_err_reg;

  // Both synchroniser flops reset to the idle (high) level. A line that is
  // low while reset is asserted therefore cannot look like a start bit
  // when reset is released.
  logic        rx_meta_reg;
  logic        rx_s_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg     <= 1'b1;
      rx_s_reg        <= 1'b1;
      state_reg       <= ST_IDLE;
      clk_count_reg   <= 16'd0;
      bit_index_reg   <= 3'd0;
      shift_reg       <= 8'h00;
      rx_byte_reg     <= 8'h00;
      rx_valid_reg    <= 1'b0;
      rx_active_reg   <= 1'b0;
      framing_err_reg <= 1'b0;
    end else begin
      rx_meta_reg <= rx_serial;
      rx_s_reg    <= rx_meta_reg;

      // Both status outputs are pulses. They are cleared by default and
      // set only in the cycle after the stop bit is sampled.
      rx_valid_reg    <= 1'b0;
      framing_err_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          clk_count_reg <= 16'd0;
          bit_index_reg <= 3'd0;
          if (!rx_s_reg) begin
            state_reg     <= ST_START;
            rx_active_reg <= 1'b1;
          end
        end

        // Re-check the line in the middle of the start bit. If the line is
        // high again, the low level was a glitch and no frame started.
        ST_START: begin
          if (clk_count_reg == HALF_LAST) begin
            clk_count_reg <= 16'd0;
            if (!rx_s_reg) begin
              state_reg <= ST_DATA;
            end else begin
              state_reg     <= ST_IDLE;
              rx_active_reg <= 1'b0;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        // Because the start bit was checked at its midpoint, counting one
        // full bit period from there lands in the middle of each data bit.
        ST_DATA: begin
          if (clk_count_reg == BIT_LAST) begin
            clk_count_reg            <= 16'd0;
            shift_reg[bit_index_reg] <= rx_s_reg;
            if (bit_index_reg != 3'd7) begin
              bit_index_reg <= bit_index_reg + 3'd1;
            end else begin
              bit_index_reg <= 3'd0;
              state_reg     <= ST_STOP;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        ST_STOP: begin
          if (clk_count_reg == BIT_LAST) begin
            clk_count_reg <= 16'd0;
            if (rx_s_reg) begin
              rx_byte_reg  <= shift_reg;
              rx_valid_reg <= 1'b1;
            end else begin
              framing_err_reg <= 1'b1;
            end
            rx_active_reg <= 1'b0;
            state_reg     <= ST_CLEANUP;
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        // Wait for the line to go high before arming for the next start
        // bit. A break (line held low) therefore cannot retrigger
        // reception. On a normal stop bit the line is already high, so
        // this state lasts one cycle. The remaining half stop bit is
        // absorbed here and in IDLE, which lets back-to-back frames be
        // received.
        ST_CLEANUP: begin
          clk_count_reg <= 16'd0;
          if (rx_s_reg) begin
            state_reg <= ST_IDLE;
          end
        end

        // Unused encodings recover to IDLE. rx_byte is deliberately held.
        default: begin
          state_reg     <= ST_IDLE;
          clk_count_reg <= 16'd0;
          bit_index_reg <= 3'd0;
          rx_active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rx_byte     = rx_byte_reg;
  assign rx_valid    = rx_valid_reg;
  assign rx_active   = rx_active_reg;
  assign framing_err = framing_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at 10 clocks per bit.
// Inputs are driven on the falling clock edge. Outputs are observed on
// the falling edge, which keeps both away from the active rising edge.
module tb_uart_rx;

  localparam int CPB  = 10;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_active;
  logic       framing_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx #(.F_CLK(1000000), .BAUD(100000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_serial  (rx_serial),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .framing_err(framing_err)
  );

  // Output monitor: counts pulses, measures pulse widths, and records
  // every byte that rx_valid announces.
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         valid_run = 0;
  int         max_valid_run = 0;
  int         ferr_run = 0;
  int         max_ferr_run = 0;
  int         active_rises = 0;
  int         active_run = 0;
  int         last_active_len = 0;
  logic       active_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid === 1'b1) begin
        valid_cnt++;
        got_q.push_back(rx_byte);
        valid_run++;
        if (valid_run > max_valid_run) max_valid_run = valid_run;
      end else begin
        valid_run = 0;
      end
      if (framing_err === 1'b1) begin
        ferr_cnt++;
        ferr_run++;
        if (ferr_run > max_ferr_run) max_ferr_run = ferr_run;
      end else begin
        ferr_run = 0;
      end
    end
    if (rx_active === 1'b1) begin
      if (!active_prev) active_rises++;
      active_run++;
    end else if (active_prev) begin
      last_active_len = active_run;
      active_run = 0;
    end
    active_prev = (rx_active === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_serial = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    send_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    $display("frame data=%02h stop=%0b", d, stop_bit);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(stop_bit, CPB);
  endtask

  // Checks one entry of the received-byte log. A missing entry is
  // reported as 0xDEAD so that it can never match a byte value.
  task automatic chk_got(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (got_q.size() > idx) ? {24'd0, got_q[idx]} : 32'hDEAD;
    chk(tag, obs, {24'd0, exp});
  endtask

  int v0, f0, r0, q0;
  logic [7:0] rnd [4];

  initial begin
    // 1: reset held with the line low
    @(negedge clk);
    rst_n = 1'b0;
    rx_serial = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_byte", {24'd0, rx_byte}, 32'h00);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_active", {31'd0, rx_active}, 32'd0);
    chk("reset_ferr", {31'd0, framing_err}, 32'd0);
    rx_serial = 1'b1;
    rst_n = 1'b1;
    idle(10);
    chk("post_reset_active", {31'd0, rx_active}, 32'd0);

    // 2: single frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt; q0 = got_q.size();
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_valid_count", valid_cnt - v0, 32'd1);
    chk_got("a5_byte_at_valid", q0, 8'hA5);
    chk("a5_rx_byte_held", {24'd0, rx_byte}, 32'hA5);
    chk("a5_no_ferr", ferr_cnt - f0, 32'd0);
    chk("a5_active_len", last_active_len, HALF + 9 * CPB);

    // 3: back-to-back 0x00 then 0xFF with no idle gap
    v0 = valid_cnt; q0 = got_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    chk("b2b_valid_count", valid_cnt - v0, 32'd2);
    chk_got("b2b_first", q0, 8'h00);
    chk_got("b2b_second", q0 + 1, 8'hFF);

    // 4: 3-cycle low glitch on the idle line is a false start
    v0 = valid_cnt; f0 = ferr_cnt; r0 = active_rises;
    $display("glitch low 3 cycles");
    send_bit(1'b0, 3);
    idle(HALF);
    chk("glitch_active_cleared", {31'd0, rx_active}, 32'd0);
    chk("glitch_active_seen", active_rises - r0, 32'd1);
    idle(10);
    chk("glitch_no_valid", valid_cnt - v0, 32'd0);
    chk("glitch_no_ferr", ferr_cnt - f0, 32'd0);
    q0 = got_q.size();
    send_frame(8'h3C, 1'b1);
    idle(20);
    chk_got("after_glitch_byte", q0, 8'h3C);

    // 5: 0x5A with a low stop bit, followed by a break of 30 cycles
    v0 = valid_cnt; f0 = ferr_cnt; r0 = active_rises;
    $display("frame data=5a stop=0 then break");
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h5A;
      send_bit(d[i], CPB);
    end
    send_bit(1'b0, 30);
    chk("break_no_restart", {31'd0, rx_active}, 32'd0);
    idle(20);
    chk("ferr_count", ferr_cnt - f0, 32'd1);
    chk("ferr_no_valid", valid_cnt - v0, 32'd0);
    chk("ferr_byte_kept", {24'd0, rx_byte}, 32'h3C);
    chk("break_single_start", active_rises - r0, 32'd1);
    q0 = got_q.size();
    send_frame(8'h81, 1'b1);
    idle(20);
    chk_got("after_ferr_byte", q0, 8'h81);

    // 6: reset in the middle of bit 4
    v0 = valid_cnt; f0 = ferr_cnt;
    $display("partial frame, reset during bit 4");
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(1'b1, CPB);
    send_bit(1'b0, HALF);
    rst_n = 1'b0;
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_byte", {24'd0, rx_byte}, 32'h00);
    chk("midreset_active", {31'd0, rx_active}, 32'd0);
    chk("midreset_valid", {31'd0, rx_valid}, 32'd0);
    rst_n = 1'b1;
    idle(20);
    chk("midreset_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
    q0 = got_q.size();
    send_frame(8'hC3, 1'b1);
    idle(20);
    chk_got("after_reset_byte", q0, 8'hC3);

    // Random bytes sent back-to-back through a serialiser in the bench
    q0 = got_q.size();
    for (int i = 0; i < 4; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      send_frame(rnd[i], 1'b1);
    end
    idle(20);
    for (int i = 0; i < 4; i++) chk_got("random_byte", q0 + i, rnd[i]);

    chk("valid_pulse_width", max_valid_run, 32'd1);
    chk("ferr_pulse_width", max_ferr_run, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
